// File: rtl/dm_mmio_bridge_if.sv
// CPU data-memory port and data-SRAM port of the MMIO bridge, bundled.
// slave  : the bridge's view.
// master : the surrounding CPU/SRAM environment's view.
interface dm_mmio_bridge_if;
  logic [3:0]  cpu_dm_w_en;
  logic [15:0] cpu_dm_address;
  logic [31:0] cpu_dm_write_data;
  logic [31:0] cpu_dm_read_data;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  modport slave (
    input  cpu_dm_w_en, cpu_dm_address, cpu_dm_write_data, sram_read_data,
    output cpu_dm_read_data, sram_w_en, sram_address, sram_write_data
  );

  modport master (
    output cpu_dm_w_en, cpu_dm_address, cpu_dm_write_data, sram_read_data,
    input  cpu_dm_read_data, sram_w_en, sram_address, sram_write_data
  );
endinterface

// File: rtl/dm_mmio_bridge.sv
// dm_mmio_bridge: routes CPU data-memory accesses to the data SRAM or to a
// small MMIO page (cycle counter, timer compare, UART TX FIFO, status).
// Read data is combinational so the CPU captures it in the same MEM cycle.
// Optional feature macro: MMIO_TIMER_EN (timer compare + sticky timer_irq).
// When undefined, TIMER_CMP reads 0, irq_pending is 0 and timer_irq is tied 0.
module dm_mmio_bridge #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CLK_DIV    = 16,
  parameter logic [7:0]  MMIO_PAGE  = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  dm_mmio_bridge_if.slave bus,
  output logic            tx_out,
  output logic            timer_irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Decode
  logic        mmio_sel_s;
  logic [1:0]  reg_idx_s;
  logic        cmp_we_s;
  logic        push_req_s;
  logic        push_ok_s;
  logic        pop_s;
  logic        stat_wr_s;
  logic [31:0] status_s;
  logic [31:0] rdata_s;
  logic [31:0] cmp_rd_s;
  logic        irq_s;

  // State
  logic [31:0]   cycle_q;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  tx_state_e     state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_q, tx_d;

  // Address bits the register map does not look at.
  logic unused_s;
  assign unused_s = ^{bus.cpu_dm_address[7:4], bus.cpu_dm_address[1:0],
                      bus.cpu_dm_write_data};

  assign mmio_sel_s = (bus.cpu_dm_address[15:8] == MMIO_PAGE);
  assign reg_idx_s  = bus.cpu_dm_address[3:2];
  assign cmp_we_s   = mmio_sel_s && (reg_idx_s == 2'd1) && (bus.cpu_dm_w_en != 4'h0);
  assign push_req_s = mmio_sel_s && (reg_idx_s == 2'd2) && bus.cpu_dm_w_en[0];
  assign stat_wr_s  = mmio_sel_s && (reg_idx_s == 2'd3) && bus.cpu_dm_w_en[0];

  // Acceptance looks only at the count at the start of the cycle, so a
  // same-cycle pop never rescues a push into a full FIFO.
  assign push_ok_s  = push_req_s && (count_q < DEPTH_C);
  assign pop_s      = (state_q == S_IDLE) && (count_q != {CW{1'b0}});

  assign bus.sram_w_en       = mmio_sel_s ? 4'h0 : bus.cpu_dm_w_en;
  assign bus.sram_address    = bus.cpu_dm_address;
  assign bus.sram_write_data = bus.cpu_dm_write_data;
  assign bus.cpu_dm_read_data = rdata_s;

  assign tx_out    = tx_q;
  assign timer_irq = irq_s;

`ifdef MMIO_TIMER_EN
  logic [31:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;

  // Timer compare byte-lane writes and sticky irq (set beats clear).
  always_comb begin
    cmp_d = cmp_q;
    irq_d = irq_q;
    for (int b = 0; b < 4; b++) begin
      if (cmp_we_s && bus.cpu_dm_w_en[b]) begin
        cmp_d[8*b +: 8] = bus.cpu_dm_write_data[8*b +: 8];
      end else begin
        cmp_d[8*b +: 8] = cmp_q[8*b +: 8];
      end
    end
    if (stat_wr_s && bus.cpu_dm_write_data[4]) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
    if (cycle_q == cmp_q) begin
      irq_d = 1'b1;
    end else begin
      irq_d = irq_d;
    end
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmp_q <= 32'hFFFF_FFFF;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end

  assign cmp_rd_s = cmp_q;
  assign irq_s    = irq_q;
`else
  assign cmp_rd_s = 32'h0000_0000;
  assign irq_s    = 1'b0;
`endif

  // STATUS register image.
  always_comb begin
    status_s              = 32'h0000_0000;
    status_s[0]           = (count_q == {CW{1'b0}});
    status_s[1]           = (count_q == DEPTH_C);
    status_s[2]           = (state_q != S_IDLE);
    status_s[3]           = ovf_q;
    status_s[4]           = irq_s;
    status_s[8 +: CW]     = count_q;
  end

  // Combinational read mux: SRAM data, or the selected MMIO register.
  always_comb begin
    rdata_s = bus.sram_read_data;
    if (mmio_sel_s) begin
      case (reg_idx_s)
        2'd0:    rdata_s = cycle_q;
        2'd1:    rdata_s = cmp_rd_s;
        2'd2:    rdata_s = 32'h0000_0000;
        2'd3:    rdata_s = status_s;
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = bus.sram_read_data;
    end
  end

  // FIFO pointer/count/overflow next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (stat_wr_s && bus.cpu_dm_write_data[3]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (push_req_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_q[wr_ptr_q] <= bus.cpu_dm_write_data[7:0];
    end
  end

  // Serializer next state; tx_d is decoded from the next state so the line
  // changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    tx_byte_d = tx_byte_q;
    tx_d      = 1'b1;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = {BW{1'b0}};
        if (pop_s) begin
          tx_byte_d = fifo_mem_q[rd_ptr_q];
          state_d   = S_START;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_START: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = {BW{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = {BW{1'b0}};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = {BW{1'b0}};
          state_d   = S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      default: begin
        bit_cnt_d = {BW{1'b0}};
        state_d   = S_IDLE;
      end
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tx_byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Cycle counter, FIFO control and serializer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q   <= 32'h0000_0000;
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      bit_cnt_q <= {BW{1'b0}};
      bit_idx_q <= 3'd0;
      tx_byte_q <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      cycle_q   <= cycle_q + 32'd1;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_byte_q <= tx_byte_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Self-checking bench for dm_mmio_bridge (FIFO_DEPTH=8, CLK_DIV=4).
// Read expectations and expected UART bytes go through queues; a line
// monitor decodes every frame on tx_out and pops the expected byte.
module tb_dm_mmio_bridge;
  localparam int DEPTH = 8;
  localparam int DIV   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_out;
  logic timer_irq;

  dm_mmio_bridge_if bus_if();

  dm_mmio_bridge #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV), .MMIO_PAGE(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .tx_out    (tx_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  // Simple word-addressed SRAM model behind the bridge.
  logic [31:0] sram_mem [0:255];
  assign bus_if.sram_read_data = sram_mem[bus_if.sram_address[9:2]];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus_if.sram_w_en[b]) sram_mem[bus_if.sram_address[9:2]][8*b +: 8] <= bus_if.sram_write_data[8*b +: 8];
    end
  end

  // Reference cycle count: value of CYCLE during the current clock period.
  logic [31:0] tb_cyc = 32'd0;
  always @(posedge clk) begin
    if (!rst) tb_cyc <= 32'd0;
    else      tb_cyc <= tb_cyc + 32'd1;
  end

  int n_total = 0;
  int n_bad   = 0;
  int frames_seen = 0;
  bit mon_on = 1'b1;
  logic [31:0] rd_q[$];
  logic [31:0] frame_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    @(negedge clk);
    bus_if.cpu_dm_w_en    = 4'h0;
    bus_if.cpu_dm_address = a;
    #1;
    check_eq(tag, bus_if.cpu_dm_read_data, rd_q.pop_front());
  endtask

  task automatic wr(input logic [3:0] be, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.cpu_dm_w_en      = be;
    bus_if.cpu_dm_address   = a;
    bus_if.cpu_dm_write_data = d;
    @(posedge clk);
    #1;
    bus_if.cpu_dm_w_en = 4'h0;
  endtask

  // UART line monitor: samples each bit mid-period and checks the byte.
  initial begin
    logic [7:0]  got;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (mon_on && rst && tx_out == 1'b0) begin
        repeat (DIV/2) @(negedge clk);
        check_eq("start_bit", {31'd0, tx_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          got[i] = tx_out;
        end
        repeat (DIV) @(negedge clk);
        check_eq("stop_bit", {31'd0, tx_out}, 32'd1);
        exp = (frame_q.size() != 0) ? frame_q.pop_front() : 32'hFFFF_FFFF;
        check_eq("frame_byte", {24'd0, got}, exp);
        frames_seen++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    bit done;
    bit hit;
    logic tx0, tx1;
    int base;
    int low_cnt;
    logic [31:0] tgt;

    bus_if.cpu_dm_w_en       = 4'h0;
    bus_if.cpu_dm_address    = 16'h0000;
    bus_if.cpu_dm_write_data = 32'h0;

    // Reset, then five idle cycles before reading CYCLE.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rd("cycle_after_5", 16'hFF00, 32'd5);
    check_eq("tx_idle", {31'd0, tx_out}, 32'd1);
    check_eq("irq_reset", {31'd0, timer_irq}, 32'd0);
    rd("status_reset", 16'hFF0C, 32'h0000_0001);
    rd("txdata_rd0", 16'hFF08, 32'h0);
`ifdef MMIO_TIMER_EN
    rd("cmp_reset", 16'hFF04, 32'hFFFF_FFFF);
`else
    rd("cmp_reset", 16'hFF04, 32'h0);
`endif

    // SRAM path, then a store into the MMIO page must not reach SRAM.
    @(negedge clk);
    bus_if.cpu_dm_w_en = 4'hF; bus_if.cpu_dm_address = 16'h0010; bus_if.cpu_dm_write_data = 32'hDEAD_BEEF;
    #1;
    check_eq("sram_we", {28'd0, bus_if.sram_w_en}, 32'hF);
    check_eq("sram_addr", {16'd0, bus_if.sram_address}, 32'h0010);
    @(posedge clk); #1; bus_if.cpu_dm_w_en = 4'h0;
    rd("sram_rd", 16'h0010, 32'hDEAD_BEEF);
    @(negedge clk);
    bus_if.cpu_dm_w_en = 4'hF; bus_if.cpu_dm_address = 16'hFF10; bus_if.cpu_dm_write_data = 32'h1234_5678;
    #1;
    check_eq("mmio_no_sram_we", {28'd0, bus_if.sram_w_en}, 32'h0);
    @(posedge clk); #1; bus_if.cpu_dm_w_en = 4'h0;
    rd("sram_untouched", 16'h0010, 32'hDEAD_BEEF);

    // Single 0x55 frame: latency and busy length.
    frame_q.push_back(32'h55);
    wr(4'h1, 16'hFF08, 32'h55);
    busy_cnt = 0; done = 1'b0; tx0 = 1'b0; tx1 = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      bus_if.cpu_dm_address = 16'hFF0C;
      #1;
      if (k == 0) tx0 = tx_out;
      if (k == 1) tx1 = tx_out;
      if (bus_if.cpu_dm_read_data[2]) busy_cnt++;
      else if (busy_cnt != 0) done = 1'b1;
    end
    check_eq("tx_after_push", {31'd0, tx0}, 32'd1);
    check_eq("tx_start_edge", {31'd0, tx1}, 32'd0);
    check_eq("busy_len", busy_cnt, 10 * DIV);

    // Overflow: DEPTH+2 back-to-back pushes; the last one is dropped.
    repeat (3) @(negedge clk);
    base = frames_seen;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i <= DEPTH) frame_q.push_back(32'hA0 + i);
      wr(4'h1, 16'hFF08, 32'hA0 + i);
    end
    rd("status_full_ovf", 16'hFF0C, (32'(DEPTH) << 8) | 32'hE);
    wr(4'h1, 16'hFF0C, 32'h8);
    rd("status_ovf_clr", 16'hFF0C, (32'(DEPTH) << 8) | 32'h6);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (frame_q.size() == 0) break;
    end
    repeat (2 * DIV) @(negedge clk);
    check_eq("drain_left", frame_q.size(), 32'd0);
    check_eq("frames_emitted", frames_seen - base, DEPTH + 1);
    rd("status_idle", 16'hFF0C, 32'h0000_0001);

`ifdef MMIO_TIMER_EN
    // Compare at CYCLE+10: irq set on the edge after the matching cycle.
    @(negedge clk);
    bus_if.cpu_dm_w_en = 4'hF; bus_if.cpu_dm_address = 16'hFF04; bus_if.cpu_dm_write_data = tb_cyc + 32'd10;
    @(posedge clk); #1; bus_if.cpu_dm_w_en = 4'h0;
    for (int m = 0; m <= 10; m++) begin
      @(negedge clk);
      bus_if.cpu_dm_address = 16'hFF0C;
      #1;
      if (m == 9)  check_eq("irq_before", {31'd0, timer_irq}, 32'd0);
      if (m == 10) check_eq("irq_rise", {31'd0, timer_irq}, 32'd1);
      if (m == 10) check_eq("status_irq", bus_if.cpu_dm_read_data, 32'h0000_0011);
    end
    wr(4'h1, 16'hFF0C, 32'h10);
    check_eq("irq_clear", {31'd0, timer_irq}, 32'd0);
    // Clear issued in the match cycle: set wins.
    @(negedge clk);
    tgt = tb_cyc + 32'd6;
    bus_if.cpu_dm_w_en = 4'hF; bus_if.cpu_dm_address = 16'hFF04; bus_if.cpu_dm_write_data = tgt;
    @(posedge clk); #1; bus_if.cpu_dm_w_en = 4'h0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (tb_cyc == tgt) begin
        check_eq("irq_pre_match", {31'd0, timer_irq}, 32'd0);
        bus_if.cpu_dm_w_en = 4'h1; bus_if.cpu_dm_address = 16'hFF0C; bus_if.cpu_dm_write_data = 32'h10;
        @(posedge clk); #1; bus_if.cpu_dm_w_en = 4'h0;
        hit = 1'b1;
      end
    end
    check_eq("match_reached", {31'd0, hit}, 32'd1);
    check_eq("irq_set_wins", {31'd0, timer_irq}, 32'd1);
    wr(4'h2, 16'hFF04, 32'h0000_AB00);
    rd("cmp_lane1", 16'hFF04, {tgt[31:16], 8'hAB, tgt[7:0]});
`else
    wr(4'hF, 16'hFF04, 32'h1234_5678);
    rd("cmp_disabled", 16'hFF04, 32'h0);
    check_eq("irq_disabled", {31'd0, timer_irq}, 32'd0);
`endif

    // Reset mid-frame with queued bytes: frame aborted, FIFO discarded.
    mon_on = 1'b0;
    for (int i = 0; i < 3; i++) wr(4'h1, 16'hFF08, 32'h3C + i);
    repeat (6 * DIV) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus_if.cpu_dm_address = 16'hFF0C;
    #1;
    check_eq("rst_tx", {31'd0, tx_out}, 32'd1);
    check_eq("rst_status", bus_if.cpu_dm_read_data, 32'h0000_0001);
    bus_if.cpu_dm_address = 16'hFF00;
    #1;
    check_eq("rst_cycle", bus_if.cpu_dm_read_data, 32'h0);
    bus_if.cpu_dm_address = 16'hFF04;
    #1;
`ifdef MMIO_TIMER_EN
    check_eq("rst_cmp", bus_if.cpu_dm_read_data, 32'hFFFF_FFFF);
`else
    check_eq("rst_cmp", bus_if.cpu_dm_read_data, 32'h0);
`endif
    check_eq("rst_irq", {31'd0, timer_irq}, 32'd0);
    low_cnt = 0;
    for (int k = 0; k < 15 * DIV; k++) begin
      @(negedge clk);
      if (tx_out == 1'b0) low_cnt++;
    end
    check_eq("no_tx_after_rst", low_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
